// File: rtl/mkio_tx_if.sv
// MKIO transmitter interface: upstream word stream in, line-driver pins and status out.
// With MKIO_TX_ERR_INJ_EN defined, a per-word inj_parity qualifier rides alongside tx_ready.
interface mkio_tx_if;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
`ifdef MKIO_TX_ERR_INJ_EN
    logic        inj_parity;
`endif
    logic        out_p;
    logic        out_n;
    logic        out_en;
    logic        busy;
    logic        word_done;
    logic        overflow;

    modport master (
`ifdef MKIO_TX_ERR_INJ_EN
        output inj_parity,
`endif
        output tx_data, tx_cd, tx_ready,
        input  out_p, out_n, out_en, busy, word_done, overflow
    );

    modport slave (
`ifdef MKIO_TX_ERR_INJ_EN
        input  inj_parity,
`endif
        input  tx_data, tx_cd, tx_ready,
        output out_p, out_n, out_en, busy, word_done, overflow
    );
endinterface

// File: rtl/mkio_tx_encoder.sv
// MKIO (GOST R 52070) Manchester-II transmitter with a 2-word buffer for gapless words.
// Optional MKIO_TX_ERR_INJ_EN: per-word parity inversion for error injection.
module mkio_tx_encoder #(
    parameter int HALF_BIT   = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    mkio_tx_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_PARITY = 2'd3;

    localparam int HB_W  = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Entry layout: {inj_parity, tx_cd, tx_data}
    logic [17:0]      fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
    logic [5:0]       bit_idx_q, bit_idx_d;
    logic [15:0]      data_q, data_d;
    logic             cd_q, cd_d, par_q, par_d;
    logic             out_p_q, out_p_d, out_en_q, out_en_d;
    logic             done_q, done_d, ovf_q, ovf_d;

    logic        fifo_empty, fifo_full, push, pop, hb_wrap, inj;
    logic [17:0] rd_entry;

`ifdef MKIO_TX_ERR_INJ_EN
    assign inj = bus.inj_parity;
`else
    assign inj = 1'b0;
`endif

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign rd_entry   = fifo_q[rd_ptr_q];
    assign hb_wrap    = (hb_cnt_q == HB_W'(HALF_BIT - 1));
    // A pop on the same edge frees a slot, so a write into a full buffer still lands.
    assign push       = bus.tx_ready && (!fifo_full || pop);
    assign ovf_d      = ovf_q | (bus.tx_ready & ~push);

    // Line level for half-bit idx of a frame: 6 sync, 32 data (MSB first), 2 parity.
    function automatic logic level(input logic [5:0] idx, input logic cd,
                                   input logic [15:0] data, input logic par);
        logic [4:0] k;
        logic       b;
        k = 5'(idx - 6'd6);
        if (idx < 6'd6) return cd ? (idx >= 6'd3) : (idx < 6'd3);
        b = (idx >= 6'd38) ? par : data[4'd15 - k[4:1]];
        return b ^ k[0];
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        hb_cnt_d  = hb_cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        cd_d      = cd_q;
        par_d     = par_q;
        out_en_d  = out_en_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        if (state_q == ST_IDLE) begin
            pop = !fifo_empty;
        end else if (hb_wrap) begin
            hb_cnt_d  = '0;
            bit_idx_d = bit_idx_q + 6'd1;
            case (state_q)
                ST_SYNC:   if (bit_idx_q == 6'd5)  state_d = ST_DATA;
                ST_DATA:   if (bit_idx_q == 6'd37) state_d = ST_PARITY;
                ST_PARITY: if (bit_idx_q == 6'd39) begin
                    done_d = 1'b1;
                    pop    = !fifo_empty;
                    if (fifo_empty) begin
                        state_d   = ST_IDLE;
                        out_en_d  = 1'b0;
                        bit_idx_d = '0;
                    end
                end
                default: ;
            endcase
        end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
        end

        if (pop) begin
            state_d   = ST_SYNC;
            hb_cnt_d  = '0;
            bit_idx_d = '0;
            data_d    = rd_entry[15:0];
            cd_d      = rd_entry[16];
            par_d     = ~^rd_entry[15:0] ^ rd_entry[17];
            out_en_d  = 1'b1;
        end

        // Registered output carries the level of the half-bit that starts on this edge.
        out_p_d = out_en_d & level(bit_idx_d, cd_d, data_d, par_d);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hb_cnt_q  <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            cd_q      <= 1'b0;
            par_q     <= 1'b0;
            out_p_q   <= 1'b0;
            out_en_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            hb_cnt_q  <= hb_cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            cd_q      <= cd_d;
            par_q     <= par_d;
            out_p_q   <= out_p_d;
            out_en_q  <= out_en_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: buffer storage is not reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {inj, bus.tx_cd, bus.tx_data};
    end

    assign bus.out_p     = out_p_q;
    assign bus.out_n     = out_en_q & ~out_p_q;
    assign bus.out_en    = out_en_q;
    assign bus.busy      = out_en_q | !fifo_empty;
    assign bus.word_done = done_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mkio_tx_encoder.sv
// Directed bench for mkio_tx_encoder; define MKIO_TX_ERR_INJ_EN to also exercise parity injection.
module tb_mkio_tx_encoder;
    localparam int HB  = 12;
    localparam int WRD = 40 * HB;

    logic clk = 1'b0;
    logic reset;
    mkio_tx_if bus();

    mkio_tx_encoder #(.HALF_BIT(HB), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: one out_p sample per cycle while out_en is high.
    bit          samples[$];
    logic [39:0] exp_q[$];
    int          en_cycles, dones, segs, outn_err;
    logic        prev_en;

    always @(negedge clk) begin
        if (bus.out_en === 1'b1) begin
            samples.push_back(bus.out_p);
            en_cycles++;
            if (!prev_en) segs++;
            if (bus.out_n !== ~bus.out_p) outn_err++;
        end
        if (bus.word_done === 1'b1) dones++;
        prev_en = bus.out_en;
    end

    task automatic mon_clear();
        samples.delete();
        exp_q.delete();
        en_cycles = 0;
        dones     = 0;
        segs      = 0;
        outn_err  = 0;
        prev_en   = 1'b0;
    endtask

    // Hand-described frame: bit 39 is the first half-bit on the line.
    function automatic logic [39:0] frame(input logic cd, input logic [15:0] d, input logic p);
        logic [39:0] f;
        f[39:34] = cd ? 6'b000111 : 6'b111000;
        for (int i = 0; i < 16; i++) f[33-2*i -: 2] = d[15-i] ? 2'b10 : 2'b01;
        f[1:0] = p ? 2'b10 : 2'b01;
        return f;
    endfunction

    function automatic logic [39:0] decim(input int k);
        logic [39:0] f;
        f = '0;
        for (int j = 0; j < 40; j++)
            if (k*WRD + j*HB + HB/2 < samples.size()) f[39-j] = samples[k*WRD + j*HB + HB/2];
        return f;
    endfunction

    task automatic strobe(input logic [15:0] d, input logic cd, input logic inj);
        @(posedge clk); #1;
        bus.tx_data  = d;
        bus.tx_cd    = cd;
        bus.tx_ready = 1'b1;
`ifdef MKIO_TX_ERR_INJ_EN
        bus.inj_parity = inj;
`endif
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
`ifdef MKIO_TX_ERR_INJ_EN
        bus.inj_parity = 1'b0;
`endif
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Compares everything captured since mon_clear against exp_q.
    task automatic verify(input string tag);
        int n, bad;
        n = exp_q.size();
        wait_idle(tag, n * WRD + 50);
        check({tag, "_en_cycles"}, 64'(en_cycles), 64'(n * WRD));
        check({tag, "_word_done"}, 64'(dones), 64'(n));
        check({tag, "_segments"}, 64'(segs), 64'd1);
        check({tag, "_out_n"}, 64'(outn_err), 64'd0);
        bad = 0;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < WRD; j++)
                if (k*WRD + j >= samples.size() || samples[k*WRD + j] !== exp_q[k][39 - j/HB]) bad++;
        check({tag, "_wave"}, 64'(bad), 64'd0);
    endtask

    initial begin
        bus.tx_data  = '0;
        bus.tx_cd    = 1'b0;
        bus.tx_ready = 1'b0;
`ifdef MKIO_TX_ERR_INJ_EN
        bus.inj_parity = 1'b0;
`endif
        mon_clear();
        reset = 1'b1;
        #1;
        check("rst_out_p",     64'(bus.out_p),     64'd0);
        check("rst_out_n",     64'(bus.out_n),     64'd0);
        check("rst_out_en",    64'(bus.out_en),    64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_word_done", 64'(bus.word_done), 64'd0);
        check("rst_overflow",  64'(bus.overflow),  64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: status word 0x0800; one data 1 -> odd parity bit 0.
        mon_clear();
        strobe(16'h0800, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_lat_busy",  64'(bus.busy),   64'd1);
        check("t1_lat_en",    64'(bus.out_en), 64'd0);
        @(negedge clk);
        check("t1_first_en", 64'(bus.out_en), 64'd1);
        check("t1_first_p",  64'(bus.out_p),  64'd1);
        exp_q.push_back(frame(1'b0, 16'h0800, 1'b0));
        verify("t1");
        check("t1_literal", 64'(decim(0)), 64'h00E156555555);

        // Test 2: 0xFFFF data sync; sixteen ones -> parity bit 1.
        mon_clear();
        strobe(16'hFFFF, 1'b1, 1'b0);
        exp_q.push_back(frame(1'b1, 16'hFFFF, 1'b1));
        verify("t2");
        check("t2_literal", 64'(decim(0)), 64'h001EAAAAAAAA);

        // Test 3: three words back-to-back, no overflow.
        mon_clear();
        strobe(16'h1234, 1'b0, 1'b0);
        strobe(16'hAAAA, 1'b1, 1'b0);
        strobe(16'h5555, 1'b1, 1'b0);
        exp_q.push_back(frame(1'b0, 16'h1234, 1'b0));
        exp_q.push_back(frame(1'b1, 16'hAAAA, 1'b1));
        exp_q.push_back(frame(1'b1, 16'h5555, 1'b1));
        verify("t3");
        check("t3_overflow", 64'(bus.overflow), 64'd0);

        // Test 4: fourth strobe finds the buffer full and is dropped.
        mon_clear();
        strobe(16'h0001, 1'b0, 1'b0);
        strobe(16'h8000, 1'b1, 1'b0);
        strobe(16'h00FF, 1'b0, 1'b0);
        check("t4_ovf_before", 64'(bus.overflow), 64'd0);
        strobe(16'hDEAD, 1'b1, 1'b0);
        @(negedge clk);
        check("t4_ovf_set", 64'(bus.overflow), 64'd1);
        exp_q.push_back(frame(1'b0, 16'h0001, 1'b0));
        exp_q.push_back(frame(1'b1, 16'h8000, 1'b0));
        exp_q.push_back(frame(1'b0, 16'h00FF, 1'b1));
        verify("t4");
        check("t4_ovf_sticky", 64'(bus.overflow), 64'd1);

        // Test 5: reset at half-bit 20 with a second word still buffered.
        strobe(16'h1234, 1'b0, 1'b0);
        strobe(16'h4321, 1'b1, 1'b0);
        begin
            int n = 0;
            while (bus.out_en !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (20 * HB) @(negedge clk);
        check("t5_en_mid", 64'(bus.out_en), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_p",    64'(bus.out_p),    64'd0);
        check("t5_rst_n",    64'(bus.out_n),    64'd0);
        check("t5_rst_en",   64'(bus.out_en),   64'd0);
        check("t5_rst_busy", 64'(bus.busy),     64'd0);
        check("t5_rst_ovf",  64'(bus.overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_after_busy", 64'(bus.busy), 64'd0);
        mon_clear();
        strobe(16'h0F0F, 1'b1, 1'b0);
        exp_q.push_back(frame(1'b1, 16'h0F0F, 1'b1));
        verify("t5");

`ifdef MKIO_TX_ERR_INJ_EN
        // Test 6: injected word carries even parity, the following one odd again.
        mon_clear();
        strobe(16'h0000, 1'b1, 1'b1);
        strobe(16'h0000, 1'b1, 1'b0);
        exp_q.push_back(frame(1'b1, 16'h0000, 1'b0));
        exp_q.push_back(frame(1'b1, 16'h0000, 1'b1));
        verify("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
